spike_aer_encoder: RTL

Downstream of `neuron_level`: consumes the per-neuron output spike vector and turns it into a serial address-event (AER) stream. Each word carries the firing neuron's index and a timestamp. Simultaneous spikes are serialised by a round-robin arbiter and buffered in a small FIFO. Words are presented on a valid/ready interface to the readout or learning logic.

---
 rtl/spike_aer_pkg.sv | 24 ++
 rtl/aer_sync_fifo.sv | 52 +++++
 rtl/spike_aer_encoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/spike_aer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spike_aer_pkg
// Purpose  : Shared types, widths and helpers for the spike AER encoder.
// Revision : 1.0 - initial release
// ============================================================================
package spike_aer_pkg;

  localparam int DROP_W   = 8;
  localparam int DEF_N    = 4;
  localparam int DEF_TS_W = 16;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Address-event word for the default neuron count and timestamp width
  typedef struct packed {
    logic [addr_width(DEF_N)-1:0] addr;
    logic [DEF_TS_W-1:0]          ts;
  } aer_word_t;

endpackage
`default_nettype wire

// File: rtl/aer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : aer_sync_fifo
// Purpose  : Synchronous fall-through FIFO with full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
module aer_sync_fifo #(
  parameter int p_depth = 8,
  parameter int p_width = 18
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic [p_width-1:0] i_data,
  input  logic               i_pop,
  output logic [p_width-1:0] o_data,
  output logic               o_empty,
  output logic               o_full
);

  localparam int PW = $clog2(p_depth);

  logic [p_width-1:0] mem [p_depth];
  logic [PW:0]        wr_ptr;
  logic [PW:0]        rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  // Head is forced to zero while empty so reset shows a clean payload
  assign o_data = o_empty ? '0 : mem[rd_ptr[PW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/spike_aer_encoder.sv
`default_nettype none
// ============================================================================
// Module   : spike_aer_encoder
// Purpose  : Serialises a spike vector into a timestamped AER word stream.
//            Optional winner-take-all filter enabled by SPIKE_AER_WTA_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spike_aer_encoder
  import spike_aer_pkg::*;
#(
  parameter int p_n        = 4,
  parameter int p_ts_width = 16,
  parameter int p_depth    = 8,
  parameter int p_inh      = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [p_n:1]                  i_spike,
  input  logic                          i_ts_clr,
  output logic                          o_aer_valid,
  input  logic                          i_aer_ready,
  output logic [addr_width(p_n)-1:0]    o_aer_addr,
  output logic [p_ts_width-1:0]         o_aer_ts,
  output logic [DROP_W-1:0]             o_drop_cnt,
  output logic                          o_full
);

  localparam int AW    = addr_width(p_n);
  localparam int WW    = AW + p_ts_width;
  localparam int DCW   = $clog2(p_n + 1);
  localparam int SUM_W = DROP_W + DCW;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [p_ts_width-1:0] ts;
  logic [p_ts_width-1:0] ts_lat [p_n];
  logic [p_n-1:0]        pending;
  logic [AW-1:0]         rr;         // zero-based form of the round-robin pointer
  logic [p_n-1:0]        raw;
  logic [p_n-1:0]        cand;
  logic [p_n-1:0]        accept;
  logic [p_n-1:0]        grant_vec;
  logic                  grant_any;
  logic [AW-1:0]         grant_idx;
  int                    probe;
  logic [DCW-1:0]        n_drop;
  logic [SUM_W-1:0]      drop_sum;
  logic [DROP_W-1:0]     drop_cnt;
  logic [WW-1:0]         head;
  logic                  empty;
  logic                  full;
  logic                  pop;

  assign raw = i_spike;

`ifdef SPIKE_AER_WTA_EN
  localparam int IW = (p_inh > 0) ? $clog2(p_inh + 1) : 1;
  logic [IW-1:0] inh_cnt;

  // Inside the window everything is refused; otherwise keep only the lowest spike
  always_comb begin
    cand = '0;
    if (inh_cnt == '0) cand = raw & (~raw + 1'b1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              inh_cnt <= '0;
    else if (inh_cnt != '0)    inh_cnt <= inh_cnt - 1'b1;
    else if (|accept)          inh_cnt <= IW'(p_inh);
  end
`else
  logic unused_inh_cfg;
  assign unused_inh_cfg = (p_inh > 0);
  assign cand           = raw;
`endif

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    probe     = 0;
    for (int i = 0; i < p_n; i++) begin
      probe = int'(rr) + i;
      if (probe >= p_n) probe = probe - p_n;
      if (!grant_any && !full && pending[probe]) begin
        grant_any = 1'b1;
        grant_idx = AW'(probe);
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (grant_any) grant_vec[grant_idx] = 1'b1;
  end

  // A granted neuron frees its slot this cycle, so a new spike on it is kept
  assign accept = cand & (~pending | grant_vec);

  always_comb begin
    n_drop = '0;
    for (int k = 0; k < p_n; k++)
      n_drop = n_drop + DCW'(raw[k] & ~accept[k]);
  end

  assign drop_sum = {{DCW{1'b0}}, drop_cnt} + {{DROP_W{1'b0}}, n_drop};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ts       <= '0;
      pending  <= '0;
      rr       <= '0;
      drop_cnt <= '0;
      for (int k = 0; k < p_n; k++) ts_lat[k] <= '0;
    end else begin
      ts      <= i_ts_clr ? '0 : ts + 1'b1;
      pending <= (pending & ~grant_vec) | accept;
      for (int k = 0; k < p_n; k++)
        if (accept[k]) ts_lat[k] <= ts;
      if (grant_any)
        rr <= (grant_idx == AW'(p_n - 1)) ? '0 : grant_idx + 1'b1;
      drop_cnt <= (drop_sum > {{DCW{1'b0}}, DROP_MAX}) ? DROP_MAX : drop_sum[DROP_W-1:0];
    end
  end

  assign pop = !empty && i_aer_ready;

  aer_sync_fifo #(
    .p_depth (p_depth),
    .p_width (WW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (grant_any),
    .i_data  ({grant_idx, ts_lat[grant_idx]}),
    .i_pop   (pop),
    .o_data  (head),
    .o_empty (empty),
    .o_full  (full)
  );

  assign o_aer_valid = !empty;
  assign o_aer_addr  = head[WW-1:p_ts_width];
  assign o_aer_ts    = head[p_ts_width-1:0];
  assign o_drop_cnt  = drop_cnt;
  assign o_full      = full;

endmodule
`default_nettype wire
